comp_pair_fifo: RTL and testbench
=================================

// Module: comp_pair_fifo
// PURPOSE
//  Downstream stage of the A/B component pair: buffers each (x, y) 8-bit result pair in a DEPTH-entry FIFO.
//  Decouples the producer from a consumer that can stall, using valid/ready handshakes on both sides.
//  Output is first-word-fall-through (FWFT): the head entry is presented combinationally.
// PARAMETERS
//  DATA_W  8  width of each lane (x and y)
//  DEPTH   4  number of entries; power of two, >= 2
// PORTS
//  clock      in   1                     sole clock, rising edge
//  reset      in   1                     synchronous, active-low; sampled on the rising edge of clock
//  in_valid   in   1                     producer presents a pair
//  in_ready   out  1                     FIFO can accept this cycle
//  in_x       in   DATA_W                lane x from upstream
//  in_y       in   DATA_W                lane y from upstream
//  out_valid  out  1                     head entry valid
//  out_ready  in   1                     consumer takes head this cycle
//  out_x      out  DATA_W                head lane x
//  out_y      out  DATA_W                head lane y
//  count      out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (reset==0 at clock edge): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1, out_x=out_y=0.
//    Storage array is not cleared. Reset mid-transfer discards all entries; no push/pop occurs that cycle.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH); out_valid = (count != 0); both derived from registered state only.
//  - Pointers: $clog2(DEPTH)+1 bits (with wrap bit); index = low bits; wrap modulo DEPTH silently.
//  - Latency: a pair pushed at edge N appears on out_* in the cycle after edge N (1-cycle latency).
//    No combinational in->out bypass when empty.
//  - Simultaneous push & pop (0<count<DEPTH): both occur; count unchanged; order preserved.
//  - Full: in_ready=0, so in_valid is ignored; a same-cycle pop does not enable a push (no pass-through).
//  - Empty: out_valid=0, out_ready ignored, out_x/out_y forced to 0.
//  - in_x/in_y are don't-care when in_valid=0. The producer holds data stable while in_valid & !in_ready.
//    The FIFO does not check this.
//  - count updates: +1 on push only, -1 on pop only, unchanged otherwise. Never exceeds DEPTH, never below 0.
// CONFIGURATION
//  - COMP_PAIR_FIFO_SUM_EN defined:
//    - Adds output port out_sum [DATA_W:0].
//    - At push time, in_x+in_y is computed zero-extended to DATA_W+1 bits and stored alongside the entry.
//    - out_sum presents the stored sum of the head entry; it is 0 when empty or in reset.
//  - COMP_PAIR_FIFO_SUM_EN undefined: the out_sum port and the sum storage do not exist.
//    All other behaviour is identical.
// STRUCTURE
//  - Shared package comp_pkg:
//    - localparam COMP_DATA_W = 8.
//    - typedef struct packed {logic [COMP_DATA_W-1:0] x, y;} comp_pair_t.
//    - typedef logic [COMP_DATA_W:0] comp_sum_t.
//  - One sub-module, comp_pair_fifo_ctrl: pointers, count, in_ready/out_valid, push/pop decode.
//  - Top level holds the storage array and the output mux/gating.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles -> out_valid=0, in_ready=1, count=0, out_x=out_y=0.
//  2 Single pair: push (x=0x12, y=0x34) with out_ready=0.
//    -> next cycle out_valid=1, out_x=0x12, out_y=0x34, count=1. Raise out_ready -> empty next cycle.
//  3 Fill: push 4 pairs (0x01..0x04) with out_ready=0 -> count=4, in_ready=0.
//    A 5th pair (0x05) offered with in_valid held is not accepted. Drain -> 0x01,0x02,0x03,0x04 in order.
//  4 Streaming: in_valid=out_ready=1 for 20 cycles with an incrementing pattern.
//    -> steady count=1 after first cycle, output = input delayed 1 cycle, pointers wrap with no loss.
//  5 Full + pop: count=4, in_valid=1, out_ready=1 -> pop occurs, push does not.
//    count=3 next cycle; push accepted the cycle after.
//  6 Mid-op reset: count=3, assert reset=0 for 1 cycle -> count=0, out_valid=0.
//    SUM_EN: with x=0xFF, y=0xFF pushed -> out_sum=0x1FE.

Source files
------------

// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comp_pkg
// Brief    : Shared types and constants for the A/B component pair datapath.
// Revision : 1.0 - initial release
// ============================================================================
package comp_pkg;

    localparam int COMP_DATA_W = 8;

    typedef struct packed {
        logic [COMP_DATA_W-1:0] x;
        logic [COMP_DATA_W-1:0] y;
    } comp_pair_t;

    typedef logic [COMP_DATA_W:0] comp_sum_t;

endpackage
`default_nettype wire

// File: rtl/comp_pair_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comp_pair_fifo_ctrl
// Brief    : Pointer/occupancy control and handshake decode for comp_pair_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module comp_pair_fifo_ctrl #(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic             pop,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] rd_idx,
    output logic [PTR_W-1:0] count
);

    localparam logic [PTR_W-1:0] c_full = PTR_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_count;

    // The wrap bit makes the pointer difference span 0..DEPTH, so occupancy
    // is read straight off the registered pointers.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign count     = w_count;
    assign in_ready  = (w_count != c_full);
    assign out_valid = (w_count != '0);

    assign push   = reset & in_valid & in_ready;
    assign pop    = reset & out_valid & out_ready;
    assign wr_idx = r_wr_ptr[IDX_W-1:0];
    assign rd_idx = r_rd_ptr[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/comp_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : comp_pair_fifo
// Brief    : FWFT valid/ready FIFO buffering (x, y) result pairs.
//            Optional stored lane sum enabled by COMP_PAIR_FIFO_SUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module comp_pair_fifo
    import comp_pkg::*;
#(
    parameter int DATA_W = COMP_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_x,
    input  logic [DATA_W-1:0]          in_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_x,
    output logic [DATA_W-1:0]          out_y,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef COMP_PAIR_FIFO_SUM_EN
    ,
    output logic [DATA_W:0]            out_sum
`endif
);

    localparam int c_idx_w = $clog2(DEPTH);

    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [2*DATA_W-1:0] w_head;

    comp_pair_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (w_out_valid),
        .push      (w_push),
        .pop       (w_pop),
        .wr_idx    (w_wr_idx),
        .rd_idx    (w_rd_idx),
        .count     (count)
    );

    // Storage is deliberately left uncleared; empty output is gated below.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[w_wr_idx] <= {in_x, in_y};
    end

    assign w_head    = r_mem[w_rd_idx];
    assign out_valid = w_out_valid;
    assign out_x     = w_out_valid ? w_head[2*DATA_W-1:DATA_W] : '0;
    assign out_y     = w_out_valid ? w_head[DATA_W-1:0]        : '0;

`ifdef COMP_PAIR_FIFO_SUM_EN
    logic [DATA_W:0] r_mem_sum [DEPTH];

    always_ff @(posedge clock) begin
        if (w_push) r_mem_sum[w_wr_idx] <= {1'b0, in_x} + {1'b0, in_y};
    end

    assign out_sum = w_out_valid ? r_mem_sum[w_rd_idx] : '0;
`endif

    // Pop only advances the read pointer inside the controller.
    logic w_unused;
    assign w_unused = w_pop;

endmodule
`default_nettype wire

// File: tb/tb_comp_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_pair_fifo
// Brief    : Self-checking bench for comp_pair_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_pair_fifo;
    import comp_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_x = '0;
    logic [DATA_W-1:0] in_y = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic [2:0]        count;
`ifdef COMP_PAIR_FIFO_SUM_EN
    logic [DATA_W:0]   out_sum;
`endif

    int checks   = 0;
    int failures = 0;

    comp_pair_t model_q[$];

    always #5 clock = ~clock;

    comp_pair_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .count     (count)
`ifdef COMP_PAIR_FIFO_SUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ":count"},     32'(count),     32'(n));
        chk({tag, ":in_ready"},  32'(in_ready),  32'(n < DEPTH));
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(n > 0));
        chk({tag, ":out_x"},     32'(out_x),     (n > 0) ? 32'(model_q[0].x) : 32'd0);
        chk({tag, ":out_y"},     32'(out_y),     (n > 0) ? 32'(model_q[0].y) : 32'd0);
`ifdef COMP_PAIR_FIFO_SUM_EN
        chk({tag, ":out_sum"},   32'(out_sum),
            (n > 0) ? 32'(model_q[0].x) + 32'(model_q[0].y) : 32'd0);
`endif
    endtask

    // Check current outputs, then advance one clock and update the model.
    task automatic cycle(input string tag);
        bit do_push, do_pop;
        comp_pair_t p;
        check_model(tag);
        do_push = reset && in_valid && (model_q.size() < DEPTH);
        do_pop  = reset && out_ready && (model_q.size() > 0);
        p.x = in_x;
        p.y = in_y;
        @(posedge clock);
        if (!reset) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(p);
        end
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_model("reset");
        chk("reset_x", 32'(out_x), 32'd0);
        reset = 1'b1;

        // Single pair
        in_valid = 1'b1; in_x = 8'h12; in_y = 8'h34;
        cycle("single_push");
        in_valid = 1'b0; in_x = 8'hAA; in_y = 8'hBB;
        chk("single_x", 32'(out_x), 32'h12);
        chk("single_y", 32'(out_y), 32'h34);
        chk("single_cnt", 32'(count), 32'd1);
        out_ready = 1'b1;
        cycle("single_pop");
        chk("single_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Fill to full, then offer a fifth pair that must be refused
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_x = 8'(i); in_y = 8'(i + 8'h10);
            cycle("fill");
        end
        chk("fill_cnt", 32'(count), 32'd4);
        chk("fill_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(out_x), 32'(i));
            cycle("drain");
        end
        chk("drain_empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Streaming: output equals input delayed one cycle
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_x = 8'(8'h40 + i); in_y = 8'(8'hC0 - i);
            cycle("stream");
            chk("stream_cnt", 32'(count), 32'd1);
            chk("stream_x", 32'(out_x), 32'(8'h40 + i));
        end
        in_valid = 1'b0;
        cycle("stream_tail");
        out_ready = 1'b0;

        // Full + pop: pop happens, push does not; push next cycle
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_x = 8'(8'h80 + i); in_y = 8'(i);
            cycle("refill");
        end
        chk("full_cnt", 32'(count), 32'd4);
        in_x = 8'h99; in_y = 8'h66; out_ready = 1'b1;
        cycle("full_pop");
        chk("full_pop_cnt", 32'(count), 32'd3);
        out_ready = 1'b0;
        cycle("full_push_after");
        chk("full_push_cnt", 32'(count), 32'd4);

        // Mid-op reset at count=3
        in_valid = 1'b0; out_ready = 1'b1;
        cycle("to_three");
        chk("three_cnt", 32'(count), 32'd3);
        out_ready = 1'b0; in_valid = 1'b1; reset = 1'b0;
        cycle("mid_reset");
        chk("mid_reset_cnt", 32'(count), 32'd0);
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        reset = 1'b1; in_valid = 1'b0;

`ifdef COMP_PAIR_FIFO_SUM_EN
        in_valid = 1'b1; in_x = 8'hFF; in_y = 8'hFF;
        cycle("sum_push");
        in_valid = 1'b0;
        chk("sum_max", 32'(out_sum), 32'h1FE);
        out_ready = 1'b1;
        cycle("sum_pop");
        chk("sum_empty", 32'(out_sum), 32'd0);
        out_ready = 1'b0;
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            in_x      = 8'($urandom);
            in_y      = 8'($urandom);
            reset     = ($urandom_range(0, 99) != 0);
            cycle("random");
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        check_model("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
